vector_lsu_sequencer: RTL and testbench
=======================================

# vector_lsu_sequencer

Parametrised vector load/store sequencer that moves one vector register (LANES × LANE_W bits) to or from word-addressed data memory, one lane per clock. It sits between the control unit and the register-file/memory pair. It replaces the fixed 4-lane, 2-bit column-counter scheme with configurable lane count, widths, vector length and optional strided addressing. A start/busy/done handshake frames each operation.

## Interface
Parameters:
- LANES, 4, lanes per vector register (power of two, ≥2)
- LANE_W, 32, bits per lane / memory word
- ADDR_W, 8, memory word-address width
- REG_ADDR_W, 4, register-file address width
- LIDX_W, $clog2(LANES), lane index width
- VLEN_W, $clog2(LANES)+1, vector-length field width

Ports:
- clk  in  1  clock, all state updates on rising edge
- reset  in  1  synchronous, active-high
- start  in  1  request; accepted only when busy=0
- op_store  in  1  0 = load (mem→reg), 1 = store (reg→mem); sampled with start
- base_addr  in  ADDR_W  lane-0 memory address; sampled with start
- stride  in  ADDR_W  address step between lanes; sampled with start (see Configuration)
- vlen  in  VLEN_W  lanes to transfer; sampled with start
- reg_addr  in  REG_ADDR_W  vector register index; sampled with start
- store_data  in  LANES*LANE_W  source vector, lane k = bits [k*LANE_W +: LANE_W]; sampled with start
- busy  out  1  operation in progress
- done  out  1  one-cycle completion pulse
- lane_idx  out  LIDX_W  lane currently issued to memory
- mem_re  out  1  memory read strobe
- mem_we  out  1  memory write strobe
- mem_addr  out  ADDR_W  memory address
- mem_wdata  out  LANE_W  store word
- mem_rdata  in  LANE_W  read data, valid the cycle after mem_re
- rf_we  out  1  register lane write strobe
- rf_waddr  out  REG_ADDR_W  register index
- rf_lane  out  LIDX_W  lane being written
- rf_wdata  out  LANE_W  lane data (= mem_rdata)

## Operation
- FSM states: IDLE, RUN, DRAIN, DONE.
- IDLE: start=1 → capture all request fields; n = min(vlen, LANES). n=0 → DONE; else RUN with lane counter k=0.
- RUN: issue lane k: mem_addr = base + k*stride mod 2^ADDR_W (wraps, no error). Load: mem_re=1. Store: mem_we=1, mem_wdata = captured lane k. k increments each cycle; after lane n-1: load → DRAIN, store → DONE.
- Load write-back: one cycle after lane k is issued, rf_we=1, rf_lane=k, rf_waddr=captured reg_addr, rf_wdata=mem_rdata. DRAIN writes back the last lane, then → DONE.
- DONE: done=1 for one cycle → IDLE.
- start while busy=1 ignored (no queuing); request inputs may change freely after acceptance.
- Lanes ≥ n are not touched in register or memory.
- vlen > LANES clamps to LANES.

## Timing
- Reset: state IDLE; busy, done, mem_re, mem_we, rf_we = 0; mem_addr, mem_wdata, lane_idx, rf_lane, rf_waddr, rf_wdata = 0. Reset mid-operation aborts at the next edge; pending load write-back is dropped.
- Start sampled at cycle 0. busy=1 from cycle 1 through the done cycle inclusive.
- Store, n≥1: mem_we cycles 1..n; done at cycle n+1.
- Load, n≥1: mem_re cycles 1..n; rf_we cycles 2..n+1; done at cycle n+2.
- n=0: done at cycle 1, no strobes.
- Earliest next start: the cycle after done (back-to-back throughput n+2 / n+3 cycles).
- All outputs are registered; strobes and address are low/zero outside active cycles.

## Configuration
- VLSU_STRIDE_EN defined: stride port honoured, addresses base + k*stride.
- Not defined: stride port present but ignored; addresses base + k (unit stride), stride multiplier logic absent.

## Test plan
- Store, base=0x10, vlen=4, store_data lanes {0xD,0xC,0xB,0xA} (lane3..0) → mem_we cycles 1–4 at 0x10..0x13 with 0xA,0xB,0xC,0xD; done at cycle 5.
- Load, reg_addr=3, base=0x20, vlen=4, memory 0x20..0x23 = 1,2,3,4 → rf_we cycles 2–5, rf_lane 0..3, rf_wdata 1..4, rf_waddr=3; done at cycle 6.
- Wrap and stride (VLSU_STRIDE_EN): load base=0xFE, stride=2, vlen=3 → mem_addr 0xFE, 0x00, 0x02; without the macro → 0xFE, 0xFF, 0x00.
- Boundaries: vlen=0 → done at cycle 1, no strobes; vlen=7 with LANES=4 → exactly 4 lanes.
- start held high during a store → second op starts only the cycle after done; busy never drops between them except that one cycle.
- reset asserted at cycle 3 of a 4-lane load → all outputs 0 next cycle, no further rf_we, done never pulses; new start then runs normally.

Source files
------------

// File: rtl/vector_lsu_sequencer.sv
// vector_lsu_sequencer: moves one LANES x LANE_W vector register to/from word memory, one lane per clock.
// Define VLSU_STRIDE_EN to honour the stride port; otherwise lanes use consecutive addresses.
module vector_lsu_sequencer #(
  parameter int LANES      = 4,
  parameter int LANE_W     = 32,
  parameter int ADDR_W     = 8,
  parameter int REG_ADDR_W = 4,
  parameter int LIDX_W     = $clog2(LANES),
  parameter int VLEN_W     = $clog2(LANES) + 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  input  logic                    op_store,
  input  logic [ADDR_W-1:0]       base_addr,
  input  logic [ADDR_W-1:0]       stride,
  input  logic [VLEN_W-1:0]       vlen,
  input  logic [REG_ADDR_W-1:0]   reg_addr,
  input  logic [LANES*LANE_W-1:0] store_data,
  output logic                    busy,
  output logic                    done,
  output logic [LIDX_W-1:0]       lane_idx,
  output logic                    mem_re,
  output logic                    mem_we,
  output logic [ADDR_W-1:0]       mem_addr,
  output logic [LANE_W-1:0]       mem_wdata,
  input  logic [LANE_W-1:0]       mem_rdata,
  output logic                    rf_we,
  output logic [REG_ADDR_W-1:0]   rf_waddr,
  output logic [LIDX_W-1:0]       rf_lane,
  output logic [LANE_W-1:0]       rf_wdata
);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  state_t                  state, state_nx;
  logic [VLEN_W-1:0]       cnt, cnt_nx;
  logic [VLEN_W-1:0]       n_q, n_nx;
  logic                    op_q, op_nx;
  logic [REG_ADDR_W-1:0]   reg_q, reg_nx;
  logic [ADDR_W-1:0]       addr_q, addr_nx;
  logic [LANES*LANE_W-1:0] data_q, data_nx;
  logic [VLEN_W-1:0]       vlen_clamp;
  logic [ADDR_W-1:0]       step_in, step_cur;

  logic                    busy_nx, done_nx, re_nx, we_nx;
  logic [ADDR_W-1:0]       maddr_nx;
  logic [LANE_W-1:0]       wdata_nx;
  logic [LIDX_W-1:0]       lidx_nx;

  assign vlen_clamp = (vlen > VLEN_W'(LANES)) ? VLEN_W'(LANES) : vlen;

`ifdef VLSU_STRIDE_EN
  logic [ADDR_W-1:0] step_q;
  assign step_in  = stride;
  assign step_cur = step_q;
  always_ff @(posedge clk) begin
    if (reset)
      step_q <= '0;
    else if (state == IDLE && start)
      step_q <= stride;
  end
`else
  logic stride_unused;
  assign stride_unused = ^stride;
  assign step_in  = ADDR_W'(1);
  assign step_cur = ADDR_W'(1);
`endif

  // Lane addresses are accumulated rather than multiplied; addr_q holds the next lane's address.
  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    n_nx     = n_q;
    op_nx    = op_q;
    reg_nx   = reg_q;
    addr_nx  = addr_q;
    data_nx  = data_q;
    busy_nx  = 1'b0;
    done_nx  = 1'b0;
    re_nx    = 1'b0;
    we_nx    = 1'b0;
    maddr_nx = '0;
    wdata_nx = '0;
    lidx_nx  = '0;
    case (state)
      IDLE: begin
        if (start) begin
          op_nx   = op_store;
          reg_nx  = reg_addr;
          n_nx    = vlen_clamp;
          busy_nx = 1'b1;
          if (vlen_clamp == '0) begin
            state_nx = DONE;
            done_nx  = 1'b1;
          end else begin
            state_nx = RUN;
            maddr_nx = base_addr;
            addr_nx  = base_addr + step_in;
            re_nx    = !op_store;
            we_nx    = op_store;
            wdata_nx = op_store ? store_data[LANE_W-1:0] : '0;
            data_nx  = store_data >> LANE_W;
            cnt_nx   = VLEN_W'(1);
          end
        end
      end
      RUN: begin
        busy_nx = 1'b1;
        if (cnt == n_q) begin
          state_nx = op_q ? DONE : DRAIN;
          done_nx  = op_q;
        end else begin
          maddr_nx = addr_q;
          addr_nx  = addr_q + step_cur;
          re_nx    = !op_q;
          we_nx    = op_q;
          wdata_nx = op_q ? data_q[LANE_W-1:0] : '0;
          data_nx  = data_q >> LANE_W;
          lidx_nx  = cnt[LIDX_W-1:0];
          cnt_nx   = cnt + VLEN_W'(1);
        end
      end
      DRAIN: begin
        busy_nx  = 1'b1;
        done_nx  = 1'b1;
        state_nx = DONE;
      end
      DONE: begin
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      cnt       <= '0;
      n_q       <= '0;
      op_q      <= 1'b0;
      reg_q     <= '0;
      addr_q    <= '0;
      data_q    <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      mem_re    <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      lane_idx  <= '0;
      rf_we     <= 1'b0;
      rf_lane   <= '0;
      rf_waddr  <= '0;
    end else begin
      state     <= state_nx;
      cnt       <= cnt_nx;
      n_q       <= n_nx;
      op_q      <= op_nx;
      reg_q     <= reg_nx;
      addr_q    <= addr_nx;
      data_q    <= data_nx;
      busy      <= busy_nx;
      done      <= done_nx;
      mem_re    <= re_nx;
      mem_we    <= we_nx;
      mem_addr  <= maddr_nx;
      mem_wdata <= wdata_nx;
      lane_idx  <= lidx_nx;
      rf_we     <= mem_re;
      rf_lane   <= mem_re ? lane_idx : '0;
      rf_waddr  <= mem_re ? reg_q : '0;
    end
  end

  // Read data arrives in the write-back cycle itself, so it is gated instead of registered.
  assign rf_wdata = rf_we ? mem_rdata : '0;

endmodule

// File: tb/tb_vector_lsu_sequencer.sv
// Scoreboard bench for vector_lsu_sequencer: a request-level model predicts every strobe and done pulse.
module tb_vector_lsu_sequencer;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         start = 1'b0;
  logic         op_store = 1'b0;
  logic [7:0]   base_addr = '0;
  logic [7:0]   stride = '0;
  logic [2:0]   vlen = '0;
  logic [3:0]   reg_addr = '0;
  logic [127:0] store_data = '0;
  logic [31:0]  mem_rdata = '0;
  logic         busy, done, mem_re, mem_we, rf_we;
  logic [1:0]   lane_idx, rf_lane;
  logic [7:0]   mem_addr;
  logic [31:0]  mem_wdata, rf_wdata;
  logic [3:0]   rf_waddr;

  vector_lsu_sequencer dut (
    .clk(clk), .reset(reset), .start(start), .op_store(op_store),
    .base_addr(base_addr), .stride(stride), .vlen(vlen), .reg_addr(reg_addr),
    .store_data(store_data), .busy(busy), .done(done), .lane_idx(lane_idx),
    .mem_re(mem_re), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_lane(rf_lane),
    .rf_wdata(rf_wdata)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          cyc;
    logic [7:0]  addr;
    logic [31:0] data;
    logic [3:0]  waddr;
    logic [1:0]  lane;
  } ev_t;

  ev_t  q_we[$], q_re[$], q_rf[$];
  int   q_done[$];
  int   cyc = 0;
  int   busy_lo = 1, busy_hi = 0;
  int   checks = 0, errors = 0;
  bit   mon_en = 1'b0;
  logic [31:0] sim_mem [256];
  logic [31:0] ref_mem [256];

  always @(posedge clk) cyc <= cyc + 1;

  // Synchronous memory: read data valid the cycle after mem_re.
  always @(posedge clk) begin
    if (mem_we) sim_mem[mem_addr] <= mem_wdata;
    if (mem_re) mem_rdata <= sim_mem[mem_addr];
  end

  task automatic chk(string nm, logic [127:0] act, logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Request-level model: cycle c is the cycle start is presented.
  task automatic expect_op(int c, bit st, logic [7:0] b, logic [7:0] s, logic [2:0] vl,
                           logic [3:0] ra, logic [127:0] sd, int abort);
    int n, d, step;
    ev_t e;
    n = (vl > 3'd4) ? 4 : int'(vl);
    step = int'(s);
`ifndef VLSU_STRIDE_EN
    step = 1;
`endif
    for (int k = 0; k < n; k++) begin
      e.addr  = 8'((int'(b) + k * step) % 256);
      e.lane  = 2'(k);
      e.waddr = ra;
      e.cyc   = c + 1 + k;
      if (st) begin
        e.data = sd[k*32 +: 32];
        ref_mem[e.addr] = e.data;
        if (abort == 0 || e.cyc <= abort) q_we.push_back(e);
      end else begin
        e.data = '0;
        if (abort == 0 || e.cyc <= abort) q_re.push_back(e);
        e.cyc  = c + 2 + k;
        e.data = ref_mem[e.addr];
        if (abort == 0 || e.cyc <= abort) q_rf.push_back(e);
      end
    end
    d = (n == 0) ? c + 1 : (st ? c + n + 1 : c + n + 2);
    busy_lo = c + 1;
    busy_hi = (abort == 0) ? d : abort;
    if (abort == 0) q_done.push_back(d);
  endtask

  always @(negedge clk) begin
    ev_t e;
    if (mon_en) begin
      chk("busy", busy, (cyc >= busy_lo && cyc <= busy_hi));
      if (mem_we) begin
        chk("we_expected", q_we.size() != 0, 1);
        if (q_we.size() != 0) begin
          e = q_we.pop_front();
          chk("we_cycle", cyc, e.cyc);
          chk("we_addr", mem_addr, e.addr);
          chk("we_data", mem_wdata, e.data);
        end
      end
      if (mem_re) begin
        chk("re_expected", q_re.size() != 0, 1);
        if (q_re.size() != 0) begin
          e = q_re.pop_front();
          chk("re_cycle", cyc, e.cyc);
          chk("re_addr", mem_addr, e.addr);
          chk("re_wdata_zero", mem_wdata, 0);
        end
      end
      if (rf_we) begin
        chk("rf_expected", q_rf.size() != 0, 1);
        if (q_rf.size() != 0) begin
          e = q_rf.pop_front();
          chk("rf_cycle", cyc, e.cyc);
          chk("rf_fields", {rf_waddr, rf_lane, rf_wdata}, {e.waddr, e.lane, e.data});
        end
      end else begin
        chk("rf_idle", {rf_lane, rf_waddr, rf_wdata}, 0);
      end
      if (!mem_re && !mem_we) chk("mem_idle", {mem_addr, mem_wdata, lane_idx}, 0);
      if (done) begin
        chk("done_expected", q_done.size() != 0, 1);
        if (q_done.size() != 0) chk("done_cycle", cyc, q_done.pop_front());
      end
    end
  end

  task automatic wait_done();
    int t = 0;
    while (!done && t < 40) begin
      @(posedge clk); #1;
      t++;
    end
    chk("done_timeout", done, 1);
    @(posedge clk); #1;
  endtask

  task automatic scramble();
    op_store   = 1'($urandom);
    base_addr  = 8'($urandom);
    stride     = 8'($urandom);
    vlen       = 3'($urandom);
    reg_addr   = 4'($urandom);
    store_data = {$urandom, $urandom, $urandom, $urandom};
  endtask

  task automatic issue(bit st, logic [7:0] b, logic [7:0] s, logic [2:0] vl,
                       logic [3:0] ra, logic [127:0] sd);
    op_store = st; base_addr = b; stride = s; vlen = vl; reg_addr = ra; store_data = sd;
    start = 1'b1;
    expect_op(cyc, st, b, s, vl, ra, sd, 0);
    @(posedge clk); #1;
    start = 1'b0;
    scramble();
    wait_done();
  endtask

  initial begin
    logic [127:0] sd;
    int c;
    for (int i = 0; i < 256; i++) begin
      sim_mem[i] = $urandom;
      ref_mem[i] = sim_mem[i];
    end
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ctl", {busy, done, mem_re, mem_we, rf_we}, 0);
    chk("rst_data", {mem_addr, mem_wdata, lane_idx, rf_lane, rf_waddr, rf_wdata}, 0);
    reset = 1'b0;
    @(posedge clk); #1;
    mon_en = 1'b1;

    issue(1'b1, 8'h10, 8'h00, 3'd4, 4'd0, {32'hD, 32'hC, 32'hB, 32'hA});
    for (int i = 0; i < 4; i++) begin
      sim_mem[8'h20 + i] = 32'(i + 1);
      ref_mem[8'h20 + i] = 32'(i + 1);
    end
    issue(1'b0, 8'h20, 8'h00, 3'd4, 4'd3, '0);
    issue(1'b0, 8'hFE, 8'h02, 3'd3, 4'd5, '0);
    issue(1'b1, 8'h50, 8'h01, 3'd0, 4'd1, {4{$urandom}});
    issue(1'b0, 8'h50, 8'h01, 3'd0, 4'd2, '0);
    issue(1'b1, 8'h60, 8'h03, 3'd7, 4'd0, {$urandom, $urandom, $urandom, $urandom});
    issue(1'b0, 8'h60, 8'h03, 3'd7, 4'd9, '0);

    // start held high across a store: second op begins the cycle after done
    sd = {$urandom, $urandom, $urandom, $urandom};
    op_store = 1'b1; base_addr = 8'h40; stride = 8'h01; vlen = 3'd3; reg_addr = 4'd0;
    store_data = sd; start = 1'b1;
    expect_op(cyc, 1'b1, 8'h40, 8'h01, 3'd3, 4'd0, sd, 0);
    @(posedge clk); #1;
    wait_done();
    expect_op(cyc, 1'b1, 8'h40, 8'h01, 3'd3, 4'd0, sd, 0);
    @(posedge clk); #1;
    start = 1'b0;
    wait_done();

    // reset during cycle 3 of a 4-lane load
    op_store = 1'b0; base_addr = 8'h30; stride = 8'h01; vlen = 3'd4; reg_addr = 4'd7;
    start = 1'b1;
    c = cyc;
    expect_op(c, 1'b0, 8'h30, 8'h01, 3'd4, 4'd7, '0, c + 3);
    @(posedge clk); #1;
    start = 1'b0;
    scramble();
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    chk("abort_ctl", {busy, done, mem_re, mem_we, rf_we}, 0);
    chk("abort_data", {mem_addr, mem_wdata, lane_idx, rf_lane, rf_waddr, rf_wdata}, 0);
    repeat (4) begin
      @(posedge clk); #1;
    end

    for (int i = 0; i < 40; i++) begin
      issue(1'($urandom), 8'($urandom), 8'($urandom), 3'($urandom_range(0, 7)), 4'($urandom),
            {$urandom, $urandom, $urandom, $urandom});
      repeat ($urandom_range(0, 2)) begin
        @(posedge clk); #1;
      end
    end

    repeat (5) begin
      @(posedge clk); #1;
    end
    chk("leftover", q_we.size() + q_re.size() + q_rf.size() + q_done.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
